// File: rtl/uc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uc_pkg
// Brief   : State codes and default widths shared by unidade_controle and
//           anything that decodes its db_estado output.
// Revision: 1.0 - initial release
// ============================================================================
package uc_pkg;

  localparam int ESTADO_W_DEF = 4;

  localparam logic [3:0] INICIAL          = 4'd0;
  localparam logic [3:0] PREPARACAO       = 4'd1;
  localparam logic [3:0] INICIO_RODADA    = 4'd2;
  localparam logic [3:0] CARREGA_DADO     = 4'd3;
  localparam logic [3:0] MOSTRA_DADO      = 4'd4;
  localparam logic [3:0] PROXIMO_MOSTRA   = 4'd5;
  localparam logic [3:0] ZERA_LEITURA     = 4'd6;
  localparam logic [3:0] ESPERA_JOGADA    = 4'd7;
  localparam logic [3:0] REGISTRA         = 4'd8;
  localparam logic [3:0] COMPARA          = 4'd9;
  localparam logic [3:0] PROXIMO_ENDERECO = 4'd10;
  localparam logic [3:0] PROXIMA_RODADA   = 4'd11;
  localparam logic [3:0] FIM_ACERTO       = 4'd12;
  localparam logic [3:0] FIM_ERRO         = 4'd13;
  localparam logic [3:0] FIM_TIMEOUT      = 4'd14;

endpackage
`default_nettype wire

// File: rtl/unidade_controle.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : unidade_controle
// Brief   : Moore control FSM driving the fluxo_dados game datapath.
//           Define UC_TIMEOUT_EN to honour the move-wait timeout.
// Revision: 1.0 - initial release
// ============================================================================
module unidade_controle
  import uc_pkg::*;
#(
  parameter int ESTADO_W = ESTADO_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                fimL,
  input  logic                fimTMR,
  input  logic                jogada_feita,
  input  logic                chavesIgualMemoria,
  input  logic                enderecoIgualLimite,
  input  logic                timeout,
  output logic                zeraR,
  output logic                zeraE,
  output logic                zeraL,
  output logic                zeraM,
  output logic                zeraTMR,
  output logic                registraR,
  output logic                registraM,
  output logic                contaE,
  output logic                contaL,
  output logic                contaTMR,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                db_timeout,
  output logic [ESTADO_W-1:0] db_estado
);

  logic [ESTADO_W-1:0] r_estado;
  logic [ESTADO_W-1:0] w_prox;
  logic [3:0]          w_prox_cod;
  logic [3:0]          w_codigo;

`ifndef UC_TIMEOUT_EN
  logic w_unused_timeout;
  assign w_unused_timeout = timeout;
`endif

  // Any code outside the 4-bit map behaves like the unused code 15.
  assign w_codigo = ((r_estado >> 4) == '0) ? r_estado[3:0] : 4'd15;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= '0;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox_cod = INICIAL;
    case (w_codigo)
      INICIAL:          w_prox_cod = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:       w_prox_cod = INICIO_RODADA;
      INICIO_RODADA:    w_prox_cod = CARREGA_DADO;
      CARREGA_DADO:     w_prox_cod = MOSTRA_DADO;
      MOSTRA_DADO: begin
        if (fimTMR) w_prox_cod = enderecoIgualLimite ? ZERA_LEITURA : PROXIMO_MOSTRA;
        else        w_prox_cod = MOSTRA_DADO;
      end
      PROXIMO_MOSTRA:   w_prox_cod = CARREGA_DADO;
      ZERA_LEITURA:     w_prox_cod = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A move in the same cycle as the timeout still counts.
        if (jogada_feita)  w_prox_cod = REGISTRA;
`ifdef UC_TIMEOUT_EN
        else if (timeout)  w_prox_cod = FIM_TIMEOUT;
`endif
        else               w_prox_cod = ESPERA_JOGADA;
      end
      REGISTRA:         w_prox_cod = COMPARA;
      COMPARA: begin
        if (!chavesIgualMemoria)              w_prox_cod = FIM_ERRO;
        else if (enderecoIgualLimite && fimL) w_prox_cod = FIM_ACERTO;
        else if (enderecoIgualLimite)         w_prox_cod = PROXIMA_RODADA;
        else                                  w_prox_cod = PROXIMO_ENDERECO;
      end
      PROXIMO_ENDERECO: w_prox_cod = ESPERA_JOGADA;
      PROXIMA_RODADA:   w_prox_cod = INICIO_RODADA;
      FIM_ACERTO:       w_prox_cod = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:         w_prox_cod = iniciar ? PREPARACAO : FIM_ERRO;
`ifdef UC_TIMEOUT_EN
      FIM_TIMEOUT:      w_prox_cod = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
      default:          w_prox_cod = INICIAL;
    endcase
  end

  always_comb begin
    w_prox       = '0;
    w_prox[3:0]  = w_prox_cod;
  end

  always_comb begin
    zeraR      = 1'b0;
    zeraE      = 1'b0;
    zeraL      = 1'b0;
    zeraM      = 1'b0;
    zeraTMR    = 1'b0;
    registraR  = 1'b0;
    registraM  = 1'b0;
    contaE     = 1'b0;
    contaL     = 1'b0;
    contaTMR   = 1'b0;
    pronto     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    db_timeout = 1'b0;
    case (w_codigo)
      PREPARACAO: begin
        zeraE   = 1'b1;
        zeraL   = 1'b1;
        zeraR   = 1'b1;
        zeraM   = 1'b1;
        zeraTMR = 1'b1;
      end
      INICIO_RODADA: begin
        zeraE   = 1'b1;
        zeraTMR = 1'b1;
      end
      CARREGA_DADO:     registraM = 1'b1;
      MOSTRA_DADO:      contaTMR  = 1'b1;
      PROXIMO_MOSTRA: begin
        contaE  = 1'b1;
        zeraTMR = 1'b1;
      end
      ZERA_LEITURA: begin
        zeraE = 1'b1;
        zeraM = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA:         registraR = 1'b1;
      PROXIMO_ENDERECO: contaE    = 1'b1;
      PROXIMA_RODADA:   contaL    = 1'b1;
      FIM_ACERTO: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
`ifdef UC_TIMEOUT_EN
      FIM_TIMEOUT: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign db_estado = r_estado;

endmodule
`default_nettype wire
